// File: rtl/memory_unit_if.sv
// Request/busy/done bus between the address-register side (master) and memory_unit (slave).
interface memory_unit_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output addr, wdata, rd, wr,
        input  rdata, busy, done, err
    );

    modport slave (
        input  addr, wdata, rd, wr,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/memory_unit.sv
// 2^AW x DW word memory with request/busy/done handshake and WAIT_CYCLES wait states.
// Optional write protection of addresses 0..PROT_TOP is enabled by defining MEM_PROTECT_EN.
module memory_unit #(
    parameter int unsigned   AW          = 12,
    parameter int unsigned   DW          = 16,
    parameter int unsigned   WAIT_CYCLES = 1,
    parameter logic [AW-1:0] PROT_TOP    = 'h00F
) (
    input  logic         clk,
    input  logic         rst,
    memory_unit_if.slave bus
);

    localparam int unsigned Depth    = 1 << AW;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

`ifdef MEM_PROTECT_EN
    localparam bit ProtEn = 1'b1;
`else
    localparam bit ProtEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          op_wr_q;
    logic [DW-1:0] rdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [DW-1:0] mem_q [Depth];

    logic prot_hit;
    logic mem_we;

    always_comb begin
        prot_hit = ProtEn && (addr_q <= PROT_TOP);
        // rst wins even on the ACCESS edge, so the array is never written under reset
        mem_we   = !rst && (state_q == StAccess) && op_wr_q && !prot_hit;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.rd && bus.wr) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (bus.rd || bus.wr) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        op_wr_q <= bus.wr;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StAccess;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= op_wr_q && prot_hit;
                    if (!op_wr_q) begin
                        rdata_q <= mem_q[addr_q];
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: one instance with one wait state, one with none.
module tb_memory_unit;

`ifdef MEM_PROTECT_EN
    localparam bit ProtEn = 1'b1;
`else
    localparam bit ProtEn = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    memory_unit_if #(.AW(12), .DW(16)) if1 ();
    memory_unit_if #(.AW(12), .DW(16)) if0 ();

    memory_unit #(
        .AW(12), .DW(16), .WAIT_CYCLES(1), .PROT_TOP(12'h00F)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    memory_unit #(
        .AW(12), .DW(16), .WAIT_CYCLES(0), .PROT_TOP(12'h00F)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on if1 (called #1 after an edge, DUT idle); lat counts edges
    // from the accepting edge through the edge that raises done.
    task automatic do_txn(input bit is_wr, input logic [11:0] a, input logic [15:0] d,
                          output int lat, output int busy_n, output logic err_o);
        if1.addr  = a;
        if1.wdata = d;
        if1.rd    = !is_wr;
        if1.wr    = is_wr;
        lat       = 0;
        busy_n    = 0;
        err_o     = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                if1.rd = 1'b0;
                if1.wr = 1'b0;
            end
            if (if1.busy) busy_n++;
            if (if1.done) begin
                lat   = k;
                err_o = if1.err;
                break;
            end
        end
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [15:0] exp);
        int   lat;
        int   bn;
        logic e;
        do_txn(1'b0, a, 16'h0000, lat, bn, e);
        check_eq({tag, "_lat"}, lat, 3);
        check_eq({tag, "_rdata"}, if1.rdata, exp);
    endtask

    initial begin
        int   lat;
        int   bn;
        logic e;
        logic [11:0] va [2];
        logic [15:0] vd [2];

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        {if1.rd, if1.wr, if0.rd, if0.wr} = 4'b0000;
        if1.addr = '0; if1.wdata = '0;
        if0.addr = '0; if0.wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_busy", if1.busy, 0);
        check_eq("rst_done", if1.done, 0);
        check_eq("rst_err", if1.err, 0);
        check_eq("rst_rdata", if1.rdata, 0);
        tick();

        // 1: write then read with one wait state
        do_txn(1'b1, 12'h123, 16'h0ABC, lat, bn, e);
        check_eq("t1_wr_lat", lat, 3);
        check_eq("t1_wr_busy", bn, 2);
        check_eq("t1_wr_err", e, 0);
        check_eq("t1_wr_rdata_kept", if1.rdata, 0);
        do_txn(1'b0, 12'h123, 16'h0000, lat, bn, e);
        check_eq("t1_rd_lat", lat, 3);
        check_eq("t1_rd_busy", bn, 2);
        check_eq("t1_rd_err", e, 0);
        check_eq("t1_rd_rdata", if1.rdata, 16'h0ABC);

        // boundary addresses, full-width data
        va[0] = 12'hFFF; vd[0] = 16'h8001;
        va[1] = 12'h800; vd[1] = 16'h7FFE;
        for (int i = 0; i < 2; i++) begin
            do_txn(1'b1, va[i], vd[i], lat, bn, e);
            check_eq("tbl_wr_lat", lat, 3);
        end
        for (int i = 0; i < 2; i++) read_chk("tbl_rd", va[i], vd[i]);

        // 2: simultaneous rd and wr
        if1.addr = 12'h050; if1.wdata = 16'h1111; if1.rd = 1'b1; if1.wr = 1'b1;
        tick();
        if1.rd = 1'b0; if1.wr = 1'b0;
        check_eq("t2_done", if1.done, 1);
        check_eq("t2_err", if1.err, 1);
        check_eq("t2_busy", if1.busy, 0);
        tick();
        check_eq("t2_done_pulse", if1.done, 0);
        check_eq("t2_busy_after", if1.busy, 0);
        read_chk("t2_rd", 12'h050, 16'h0000);

        // 3: request while busy is ignored; latched addr/wdata are kept
        if1.addr = 12'h300; if1.wdata = 16'h1234; if1.wr = 1'b1;
        tick();
        if1.addr = 12'h124; if1.wdata = 16'h5555;
        tick();
        if1.wr = 1'b0;
        check_eq("t3_busy", if1.busy, 1);
        tick();
        check_eq("t3_done", if1.done, 1);
        check_eq("t3_err", if1.err, 0);
        tick();
        check_eq("t3_no_queue", if1.busy, 0);
        read_chk("t3_rd124", 12'h124, 16'h0000);
        read_chk("t3_rd300", 12'h300, 16'h1234);

        // 4: rst during WAIT of a write
        if1.addr = 12'h200; if1.wdata = 16'hFFFF; if1.wr = 1'b1;
        tick();
        if1.wr = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_busy", if1.busy, 0);
        check_eq("t4_done", if1.done, 0);
        check_eq("t4_err", if1.err, 0);
        check_eq("t4_rdata", if1.rdata, 0);
        tick();
        check_eq("t4_no_done", if1.done, 0);
        read_chk("t4_rd200", 12'h200, 16'h0000);

        // rst coinciding with the ACCESS edge must block the write
        if1.addr = 12'h201; if1.wdata = 16'hBEEF; if1.wr = 1'b1;
        tick();
        if1.wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4b_done", if1.done, 0);
        tick();
        read_chk("t4b_rd201", 12'h201, 16'h0000);

        // 5: zero wait states, back-to-back read in the done cycle
        if0.addr = 12'hFFF; if0.wdata = 16'hFFFF; if0.wr = 1'b1;
        tick();
        if0.wr = 1'b0;
        check_eq("t5_wr_busy", if0.busy, 1);
        check_eq("t5_wr_nodone", if0.done, 0);
        tick();
        check_eq("t5_wr_done", if0.done, 1);
        check_eq("t5_wr_busy_lo", if0.busy, 0);
        check_eq("t5_wr_rdata_kept", if0.rdata, 0);
        if0.rd = 1'b1;
        tick();
        if0.rd = 1'b0;
        check_eq("t5_rd_accepted", if0.busy, 1);
        check_eq("t5_rd_nodone", if0.done, 0);
        tick();
        check_eq("t5_rd_done", if0.done, 1);
        check_eq("t5_rd_rdata", if0.rdata, 16'hFFFF);

        // 6: protected region
        do_txn(1'b1, 12'h005, 16'h00AA, lat, bn, e);
        check_eq("t6_prot_lat", lat, 3);
        check_eq("t6_prot_err", e, ProtEn ? 1 : 0);
        read_chk("t6_rd005", 12'h005, ProtEn ? 16'h0000 : 16'h00AA);
        do_txn(1'b1, 12'h010, 16'h0BEE, lat, bn, e);
        check_eq("t6_open_err", e, 0);
        read_chk("t6_rd010", 12'h010, 16'h0BEE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
